// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: register address
// width, FSM state encoding and the in-flight writer scoreboard slot.
package pipe_pkg;

    localparam int RA_W = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    // One in-flight writer: valid bit plus the destination register.
    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
    } sb_slot_t;

    localparam sb_slot_t SB_EMPTY = '{v: 1'b0, rd: '0};

    // True when the slot holds a live writer of register r.
    function automatic logic slot_hit(input sb_slot_t s, input logic [RA_W-1:0] r);
        return s.v && (s.rd == r);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage instruction fields, EX branch resolution and the pipeline control
// outputs, bundled between the datapath (master) and the controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_pkg::*;

    logic            id_valid;
    logic [RA_W-1:0] id_rs;
    logic            id_rs_used;
    logic [RA_W-1:0] id_rt;
    logic            id_rt_used;
    logic [RA_W-1:0] id_rd;
    logic            id_we;
    logic            id_halt;
    logic            ex_br_taken;

    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush_if;
    logic             flush_id;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_we,
               id_halt, ex_br_taken,
        input  stall_if, stall_id, bubble_ex, flush_if, flush_id, halted,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_we,
               id_halt, ex_br_taken,
        output stall_if, stall_id, bubble_ex, flush_if, flush_id, halted,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sb_match.sv
// Compares one source register against the EX/MEM/WB writer slots. Register 0
// is hard-wired and never hits; the WB slot is ignored when the register file
// writes before it reads in the same cycle.
module sb_match
    import pipe_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic [RA_W-1:0] r,
    input  sb_slot_t        sb_ex,
    input  sb_slot_t        sb_mem,
    input  sb_slot_t        sb_wb,
    output logic            hit
);

    logic wb_hit;

    // WB slot only counts when the register file cannot forward its write.
    assign wb_hit = (WB_BYPASS == 1'b0) && slot_hit(sb_wb, r);

    assign hit = (r != '0) && (slot_hit(sb_ex, r) || slot_hit(sb_mem, r) || wb_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the IF/ID/EX/MEM/WB pipeline: RAW hazard stalls
// with EX bubbles, taken-branch kills of IF/ID, halt drain/freeze, and
// stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave ctl
);

    state_e           state_q, state_d;
    sb_slot_t         sb_ex_q, sb_ex_d;
    sb_slot_t         sb_mem_q, sb_mem_d;
    sb_slot_t         sb_wb_q, sb_wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic rs_hit, rt_hit;
    logic run;
    logic hazard;
    logic hz_stall;
    logic issue;
    logic kill;
    logic sb_empty;

    sb_match #(.WB_BYPASS(WB_BYPASS)) u_rs_match (
        .r      (ctl.id_rs),
        .sb_ex  (sb_ex_q),
        .sb_mem (sb_mem_q),
        .sb_wb  (sb_wb_q),
        .hit    (rs_hit)
    );

    sb_match #(.WB_BYPASS(WB_BYPASS)) u_rt_match (
        .r      (ctl.id_rt),
        .sb_ex  (sb_ex_q),
        .sb_mem (sb_mem_q),
        .sb_wb  (sb_wb_q),
        .hit    (rt_hit)
    );

    // Hazard/issue qualification; a taken branch overrides a hazard because
    // the ID instruction is on the wrong path and is killed instead.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        run      = (state_q == RUN);
        hazard   = ctl.id_valid && ((ctl.id_rs_used && rs_hit) || (ctl.id_rt_used && rt_hit));
        hz_stall = hazard && !ctl.ex_br_taken;
        issue    = ctl.id_valid && !hazard && !ctl.ex_br_taken && run;
        kill     = ctl.ex_br_taken && run;
        sb_empty = !sb_ex_q.v && !sb_mem_q.v && !sb_wb_q.v;
    end

    // Pipeline control outputs, purely combinational from state and inputs.
    always_comb begin
        ctl.stall_if  = hz_stall || (state_q == DRAIN) || (state_q == HALTED);
        ctl.stall_id  = ctl.stall_if;
        ctl.bubble_ex = hz_stall || !run;
        ctl.flush_if  = kill;
        ctl.flush_id  = kill;
        ctl.halted    = (state_q == HALTED);
        ctl.stall_cnt = stall_cnt_q;
        ctl.flush_cnt = flush_cnt_q;
    end

    // Halt FSM: stop issuing once HALT issues, freeze when the scoreboard drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (issue && ctl.id_halt) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (sb_empty) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Scoreboard shift: only issued writers of a non-zero register become live.
    always_comb begin
        sb_ex_d    = SB_EMPTY;
        sb_ex_d.v  = issue && ctl.id_we && (ctl.id_rd != '0);
        sb_ex_d.rd = ctl.id_rd;
        sb_mem_d   = sb_ex_q;
        sb_wb_d    = sb_mem_q;
    end

    // Performance counters; both only move in RUN, so they freeze once halted.
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(hz_stall && run);
        flush_cnt_d = flush_cnt_q + CNT_W'(kill);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values and the scoreboard shifts by exactly one slot.
        if (rst) begin
            state_q     <= RUN;
            sb_ex_q     <= SB_EMPTY;
            sb_mem_q    <= SB_EMPTY;
            sb_wb_q     <= SB_EMPTY;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sb_ex_q     <= sb_ex_d;
            sb_mem_q    <= sb_mem_d;
            sb_wb_q     <= sb_wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Two instances (WB_BYPASS=1 and 0)
// see identical stimulus. A reference model tracks, per register, the cycle of
// its most recent issued write; a read is blocked while that write is younger
// than the bypass-dependent window. Expected outputs go into a queue that a
// separate negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32)) if_byp ();
    pipe_hazard_ctrl_if #(.CNT_W(32)) if_nob ();

    pipe_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(32)) u_dut_byp (
        .clk (clk),
        .rst (rst),
        .ctl (if_byp.slave)
    );

    pipe_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(32)) u_dut_nob (
        .clk (clk),
        .rst (rst),
        .ctl (if_nob.slave)
    );

    typedef struct {
        int          dut;
        int          cyc;
        logic [5:0]  ctrl;  // stall_if, stall_id, bubble_ex, flush_if, flush_id, halted
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state, index 0 = WB bypass, 1 = no bypass.
    int          last_wr  [2][32];
    int          last_any [2];
    bit          m_drain  [2];
    bit          m_halted [2];
    int unsigned m_sc     [2];
    int unsigned m_fc     [2];
    int          cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        for (int i = 0; i < 32; i++) last_wr[k][i] = -1000;
        last_any[k] = -1000;
        m_drain[k]  = 1'b0;
        m_halted[k] = 1'b0;
        m_sc[k]     = 0;
        m_fc[k]     = 0;
    endtask

    // A register is blocked while its latest write issued within the window.
    function automatic bit blocked(input int k, input logic [RA_W-1:0] r);
        int win;
        win = (k == 0) ? 2 : 3;
        return (r != 0) && (last_wr[k][r] >= cyc - win);
    endfunction

    task automatic step(input bit v, input logic [RA_W-1:0] rs, input bit rsu,
                        input logic [RA_W-1:0] rt, input bit rtu,
                        input logic [RA_W-1:0] rd, input bit we,
                        input bit halt, input bit br, input bit r);
        @(posedge clk);
        #1;
        rst = r;
        if_byp.id_valid = v;  if_byp.id_rs = rs; if_byp.id_rs_used = rsu;
        if_byp.id_rt = rt;    if_byp.id_rt_used = rtu; if_byp.id_rd = rd;
        if_byp.id_we = we;    if_byp.id_halt = halt;   if_byp.ex_br_taken = br;
        if_nob.id_valid = v;  if_nob.id_rs = rs; if_nob.id_rs_used = rsu;
        if_nob.id_rt = rt;    if_nob.id_rt_used = rtu; if_nob.id_rd = rd;
        if_nob.id_we = we;    if_nob.id_halt = halt;   if_nob.ex_br_taken = br;
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            bit   hz, run, hold, fl, iss;
            hz   = v && ((rsu && blocked(k, rs)) || (rtu && blocked(k, rt)));
            run  = !m_drain[k] && !m_halted[k];
            hold = (hz && !br) || !run;
            fl   = br && run;
            e.dut  = k;
            e.cyc  = cyc;
            e.ctrl = {hold, hold, hold, fl, fl, m_halted[k]};
            e.sc   = m_sc[k];
            e.fc   = m_fc[k];
            exp_q.push_back(e);
            if (r) begin
                model_reset(k);
            end else begin
                iss = v && !hz && !br && run;
                if (run && hz && !br) m_sc[k]++;
                if (fl) m_fc[k]++;
                if (m_drain[k] && (cyc - last_any[k] > 3)) begin
                    m_drain[k]  = 1'b0;
                    m_halted[k] = 1'b1;
                end else if (iss && halt) begin
                    m_drain[k] = 1'b1;
                end
                if (iss && we && rd != 0) begin
                    last_wr[k][rd] = cyc;
                    last_any[k]    = cyc;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [RA_W-1:0] rd);
        step(1, 0, 0, 0, 0, rd, 1, 0, 0, 0);
    endtask

    task automatic rd_rs(input logic [RA_W-1:0] rs, input int n);
        for (int i = 0; i < n; i++) step(1, rs, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every queued expectation against the matching DUT.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [5:0]  act_ctrl;
                logic [31:0] act_sc, act_fc;
                e = exp_q.pop_front();
                if (e.dut == 0) begin
                    act_ctrl = {if_byp.stall_if, if_byp.stall_id, if_byp.bubble_ex,
                                if_byp.flush_if, if_byp.flush_id, if_byp.halted};
                    act_sc   = if_byp.stall_cnt;
                    act_fc   = if_byp.flush_cnt;
                end else begin
                    act_ctrl = {if_nob.stall_if, if_nob.stall_id, if_nob.bubble_ex,
                                if_nob.flush_if, if_nob.flush_id, if_nob.halted};
                    act_sc   = if_nob.stall_cnt;
                    act_fc   = if_nob.flush_cnt;
                end
                check($sformatf("ctrl dut%0d cyc%0d", e.dut, e.cyc), 64'(act_ctrl), 64'(e.ctrl));
                check($sformatf("stall_cnt dut%0d cyc%0d", e.dut, e.cyc), 64'(act_sc), 64'(e.sc));
                check($sformatf("flush_cnt dut%0d cyc%0d", e.dut, e.cyc), 64'(act_fc), 64'(e.fc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset(0);
        model_reset(1);
        if_byp.id_valid = 0; if_byp.id_rs = 0; if_byp.id_rs_used = 0; if_byp.id_rt = 0;
        if_byp.id_rt_used = 0; if_byp.id_rd = 0; if_byp.id_we = 0; if_byp.id_halt = 0;
        if_byp.ex_br_taken = 0;
        if_nob.id_valid = 0; if_nob.id_rs = 0; if_nob.id_rs_used = 0; if_nob.id_rt = 0;
        if_nob.id_rt_used = 0; if_nob.id_rd = 0; if_nob.id_we = 0; if_nob.id_halt = 0;
        if_nob.ex_br_taken = 0;

        // Reset, then idle: all outputs and counters zero.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Back-to-back RAW on r3, held in ID until it issues.
        wr(3);
        rd_rs(3, 4);
        idle(3);

        // Same register in rs and rt counts once.
        wr(4);
        for (int i = 0; i < 4; i++) step(1, 4, 1, 4, 1, 0, 0, 0, 0, 0);
        idle(3);

        // r0 never creates a hazard.
        wr(0);
        rd_rs(0, 2);
        idle(3);

        // Taken branch with a hazard in ID: killed, not stalled, not recorded.
        wr(7);
        step(1, 7, 1, 0, 0, 9, 1, 0, 1, 0);
        rd_rs(9, 2);
        idle(3);

        // HALT while r5 and r6 are in flight: drain, freeze, counters hold.
        wr(5);
        wr(6);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 5, 1, 6, 1, 0, 0, 0, 1, 0);

        // Reset mid-drain, then dependent read of r5 issues cleanly.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        wr(5);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        rd_rs(5, 2);

        // Reset while a stall is active.
        wr(3);
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 1);
        rd_rs(3, 2);

        // Randomized traffic with occasional halts, branches and resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 RA_W'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                 RA_W'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                 RA_W'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 79) == 0);
        end

        repeat (2) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Keeps a scoreboard of in-flight register writers in EX/MEM/WB; detects RAW hazards for the instruction in ID and stalls IF/ID while inserting EX bubbles.
- Kills the wrong-path IF/ID instructions when EX resolves a taken branch.
- Drains and freezes the pipeline on a halt instruction; exposes stall/flush cycle counters.

Parameters:
- RA_W, 5, register address width; register 0 never creates a hazard.
- WB_BYPASS, 1, 1 = regfile writes before reads in the same cycle, so the WB slot is not compared; 0 = WB slot compared.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  RA_W  first source register of the ID instruction
- id_rs_used  in  1  rs is read
- id_rt  in  RA_W  second source register
- id_rt_used  in  1  rt is read
- id_rd  in  RA_W  destination register of the ID instruction
- id_we  in  1  ID instruction writes id_rd
- id_halt  in  1  ID instruction is HALT
- ex_br_taken  in  1  branch in EX is taken (isBranch && cond)
- stall_if  out  1  hold PC and IF/ID register
- stall_id  out  1  hold the ID stage
- bubble_ex  out  1  load NOP into ID/EX
- flush_if  out  1  replace IF/ID contents with NOP
- flush_id  out  1  replace ID/EX contents with NOP
- halted  out  1  pipeline frozen after HALT drained
- stall_cnt  out  CNT_W  cycles with a hazard stall
- flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Scoreboard: 3 slots, sb_ex, sb_mem, sb_wb, each {v, rd}. Every clk: sb_wb<=sb_mem; sb_mem<=sb_ex; sb_ex<={issue && id_we && id_rd!=0, id_rd}.
- issue = id_valid && !hazard && !ex_br_taken && state==RUN.
- match(r) = r!=0 && ((sb_ex.v && sb_ex.rd==r) || (sb_mem.v && sb_mem.rd==r) || (!WB_BYPASS && sb_wb.v && sb_wb.rd==r)).
- hazard = id_valid && ((id_rs_used && match(id_rs)) || (id_rt_used && match(id_rt))). This is combinational in the same cycle.
- Outputs are combinational from state, scoreboard and inputs:
  - stall_if = stall_id = hazard && !ex_br_taken, or state in {DRAIN, HALTED}.
  - bubble_ex = (hazard && !ex_br_taken) || state!=RUN.
  - flush_if = flush_id = ex_br_taken && state==RUN.
- Priority: a taken branch beats a hazard. The ID instruction is wrong-path, so it is killed rather than stalled, and no stall is counted that cycle.
- FSM states and transitions:
  - RUN -> DRAIN when issue && id_halt; HALT itself enters the scoreboard as a non-writer.
  - DRAIN -> HALTED when all sb v==0 at the clock edge.
  - HALTED: stays until rst; halted=1.
  - A taken branch in EX during the cycle HALT sits in ID kills HALT and keeps the FSM in RUN.
- Counters:
  - stall_cnt +1 each cycle with hazard && !ex_br_taken && state==RUN.
  - flush_cnt +1 each cycle flush_if==1.
  - Both wrap modulo 2^CNT_W and freeze in HALTED.
- Reset, synchronous, applies even mid-stall, mid-flush or in DRAIN: all sb v=0, state=RUN, counters=0. Outputs are therefore all 0 in the first cycle after reset when id_valid=0.
- Latency: a producer issued in cycle t blocks a dependent ID instruction in cycles t+1 and t+2, plus t+3 if WB_BYPASS=0. The dependent instruction issues at t+3, or t+4 with WB_BYPASS=0.
- The same register in both rs and rt gives one hazard, not double-counted. A stalled ID instruction re-evaluates every cycle.

Decomposition:
- Shared package pipe_pkg: RA_W, the FSM state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2), and a scoreboard-slot struct {v, rd}.
- One sub-module, sb_match: compares one register address against the 3 slots and yields a hit. Instantiate it twice, for rs and rt.

Test Plan:
- Back-to-back RAW: issue write r3, then ID reads rs=3 (WB_BYPASS=1) -> stall_if/bubble_ex high for exactly 2 cycles, issue on the 3rd cycle, stall_cnt=2.
- Same with WB_BYPASS=0 -> 3 stall cycles, stall_cnt=3. Dependent read of r0 after a write to r0 -> no stall.
- Taken branch with a hazard in ID in the same cycle -> flush_if=flush_id=1, stall_if=0, flush_cnt=1, stall_cnt unchanged, and the killed instruction is not placed in sb_ex.
- HALT issued with writers r5 and r6 in flight -> DRAIN with stall_if=1 for 2 cycles; halted=1 after the scoreboard empties; counters frozen over the next 10 cycles.
- rst asserted in DRAIN with sb_ex.v=1 -> next cycle state=RUN, scoreboard empty, halted=0, counters=0, and a dependent ID read of r5 issues without a stall.
